// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl shared definitions.
// Register map, pin cfg codes and address helper.
package gpio_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_STATUS   = 8'h01;
  localparam logic [7:0] ADDR_CFG0     = 8'h02;
  localparam logic [7:0] ADDR_PRESCALE = 8'h08;
  localparam logic [7:0] ADDR_PWM0     = 8'h10;

  localparam int NUM_PWM = 8;

  localparam logic [3:0] CFG_INPUT      = 4'd0;
  localparam logic [3:0] CFG_TOTEM      = 4'd1;
  localparam logic [3:0] CFG_OPEN_DRAIN = 4'd2;
  localparam logic [3:0] CFG_WIRED_OR   = 4'd3;
  localparam logic [3:0] CFG_DBG        = 4'd7;
  localparam logic [3:0] CFG_PWM0       = 4'd8;

  // Eight cfg nibbles per CFG word.
  function automatic logic [7:0] cfg_addr(input int p);
    return ADDR_CFG0 + 8'(p / 8);
  endfunction

endpackage

// File: rtl/gpio_pwm_chan.sv
// One PWM channel: shadow/active period and duty,
// tick-driven counter and registered output.
module gpio_pwm_chan #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             wr_i,
  input  logic             en_i,
  input  logic [PWM_W-1:0] per_i,
  input  logic [PWM_W-1:0] duty_i,
  output logic [31:0]      rdata_o,
  output logic             pwm_o
);

  logic             en_q, en_d;
  logic [PWM_W-1:0] sh_per_q, sh_per_d;
  logic [PWM_W-1:0] sh_duty_q, sh_duty_d;
  logic [PWM_W-1:0] act_per_q, act_per_d;
  logic [PWM_W-1:0] act_duty_q, act_duty_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  always_comb begin
    en_d       = en_q;
    sh_per_d   = sh_per_q;
    sh_duty_d  = sh_duty_q;
    act_per_d  = act_per_q;
    act_duty_d = act_duty_q;
    cnt_d      = cnt_q;
    if (wr_i) begin
      en_d      = en_i;
      sh_per_d  = per_i;
      sh_duty_d = duty_i;
    end
    // Idle or just-enabled channels follow the shadow directly.
    if (!en_d || !en_q) begin
      cnt_d      = '0;
      act_per_d  = sh_per_d;
      act_duty_d = sh_duty_d;
    end else if (tick_i) begin
      if (cnt_q == act_per_q) begin
        cnt_d      = '0;
        act_per_d  = sh_per_d;
        act_duty_d = sh_duty_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    out_d = en_d && (cnt_d < act_duty_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      sh_per_q   <= '0;
      sh_duty_q  <= '0;
      act_per_q  <= '0;
      act_duty_q <= '0;
      cnt_q      <= '0;
      out_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      sh_per_q   <= sh_per_d;
      sh_duty_q  <= sh_duty_d;
      act_per_q  <= act_per_d;
      act_duty_q <= act_duty_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    rdata_o              = '0;
    rdata_o[31]          = en_q;
    rdata_o[16+:PWM_W]   = sh_per_q;
    rdata_o[PWM_W-1:0]   = sh_duty_q;
  end

  assign pwm_o = out_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO bank register controller: pin ctrl/cfg,
// synchronised status and eight shared PWM channels.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NUM_PINS = 16,
  parameter int PWM_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lb_wr,
  input  logic                  lb_rd,
  input  logic [7:0]            lb_addr,
  input  logic [31:0]           lb_wr_d,
  output logic [31:0]           lb_rd_d,
  output logic                  lb_rd_rdy,
  output logic [NUM_PINS-1:0]   pin_ctrl,
  output logic [4*NUM_PINS-1:0] pin_cfg,
  input  logic [NUM_PINS-1:0]   pin_status,
  output logic [7:0]            pwm_pin
);

  logic [NUM_PINS-1:0]   ctrl_q, ctrl_d;
  logic [4*NUM_PINS-1:0] cfg_q, cfg_d;
  logic [NUM_PINS-1:0]   sync1_q, sync2_q;
  logic [15:0]           pre_p_q, pre_p_d;
  logic [15:0]           pre_cnt_q, pre_cnt_d;
  logic [31:0]           rd_q, rd_d;
  logic                  rdy_q;
  logic                  wr_ctrl, wr_pre, pwm_hit, tick;
  logic [NUM_PWM-1:0]    wr_pwm;
  logic [31:0]           pwm_rdata [NUM_PWM];

  assign wr_ctrl = lb_wr && (lb_addr == ADDR_CTRL);
  assign wr_pre  = lb_wr && (lb_addr == ADDR_PRESCALE);
  assign pwm_hit = lb_addr[7:3] == ADDR_PWM0[7:3];

  // A PRESCALE write reloads the counter and suppresses that tick.
  assign tick = !wr_pre && (pre_cnt_q == '0);

  always_comb begin
    ctrl_d    = ctrl_q;
    cfg_d     = cfg_q;
    pre_p_d   = pre_p_q;
    pre_cnt_d = pre_cnt_q - 1'b1;
    if (wr_ctrl) ctrl_d = lb_wr_d[NUM_PINS-1:0];
    for (int p = 0; p < NUM_PINS; p++) begin
      if (lb_wr && (lb_addr == cfg_addr(p)))
        cfg_d[4*p+:4] = lb_wr_d[4*(p%8)+:4];
    end
    if (wr_pre) begin
      pre_p_d   = lb_wr_d[15:0];
      pre_cnt_d = lb_wr_d[15:0];
    end else if (tick) begin
      pre_cnt_d = pre_p_q;
    end
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      lb_addr == ADDR_CTRL:     rd_d[NUM_PINS-1:0] = ctrl_q;
      lb_addr == ADDR_STATUS:   rd_d[NUM_PINS-1:0] = sync2_q;
      lb_addr == ADDR_PRESCALE: rd_d[15:0] = pre_p_q;
      pwm_hit:                  rd_d = pwm_rdata[lb_addr[2:0]];
      default: begin
        for (int p = 0; p < NUM_PINS; p++) begin
          if (lb_addr == cfg_addr(p))
            rd_d[4*(p%8)+:4] = cfg_q[4*p+:4];
        end
      end
    endcase
    if (!lb_rd) rd_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      cfg_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_p_q   <= '0;
      pre_cnt_q <= '0;
      rd_q      <= '0;
      rdy_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      cfg_q     <= cfg_d;
      sync1_q   <= pin_status;
      sync2_q   <= sync1_q;
      pre_p_q   <= pre_p_d;
      pre_cnt_q <= pre_cnt_d;
      rd_q      <= rd_d;
      rdy_q     <= lb_rd;
    end
  end

  for (genvar c = 0; c < NUM_PWM; c++) begin : g_ch
    assign wr_pwm[c] = lb_wr && pwm_hit && (lb_addr[2:0] == 3'(c));
    gpio_pwm_chan #(.PWM_W(PWM_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .wr_i    (wr_pwm[c]),
      .en_i    (lb_wr_d[31]),
      .per_i   (lb_wr_d[16+:PWM_W]),
      .duty_i  (lb_wr_d[PWM_W-1:0]),
      .rdata_o (pwm_rdata[c]),
      .pwm_o   (pwm_pin[c])
    );
  end

  assign pin_ctrl  = ctrl_q;
  assign pin_cfg   = cfg_q;
  assign lb_rd_d   = rd_q;
  assign lb_rd_rdy = rdy_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: registers, status
// sync, PWM waveforms, shadow update and reset.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lb_wr = 1'b0;
  logic        lb_rd = 1'b0;
  logic [7:0]  lb_addr = '0;
  logic [31:0] lb_wr_d = '0;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic [15:0] pin_ctrl;
  logic [63:0] pin_cfg;
  logic [15:0] pin_status = '0;
  logic [7:0]  pwm_pin;

  int n_chk = 0;
  int n_fail = 0;

  gpio_ctrl #(.NUM_PINS(16), .PWM_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .lb_wr     (lb_wr),
    .lb_rd     (lb_rd),
    .lb_addr   (lb_addr),
    .lb_wr_d   (lb_wr_d),
    .lb_rd_d   (lb_rd_d),
    .lb_rd_rdy (lb_rd_rdy),
    .pin_ctrl  (pin_ctrl),
    .pin_cfg   (pin_cfg),
    .pin_status(pin_status),
    .pwm_pin   (pwm_pin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    lb_wr = 1'b1; lb_addr = a; lb_wr_d = d;
    @(negedge clk);
    lb_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    lb_rd = 1'b1; lb_addr = a;
    @(negedge clk);
    lb_rd = 1'b0;
    d = lb_rd_d;
    n_chk++;
    assert (lb_rd_rdy === 1'b1) else begin
      n_fail++;
      $error("FAIL rdy@%h: observed %b expected 1", a, lb_rd_rdy);
    end
  endtask

  task automatic sample(input int n, input int ch, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = pwm_pin[ch];
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pwm(input bit en, input int n, input int d);
    return {en, 7'd0, 8'(n), 8'd0, 8'(d)};
  endfunction

  initial begin
    logic [31:0] d;
    logic [63:0] v, e;
    int hi;

    // 1. reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cfg", pin_cfg, 64'd0);
    chk("rst_ctrl", {48'd0, pin_ctrl}, 64'd0);
    chk("rst_pwm", {56'd0, pwm_pin}, 64'd0);
    chk("rst_rdy", {63'd0, lb_rd_rdy}, 64'd0);
    rd(8'h02, d);
    chk("rst_cfg0_rd", {32'd0, d}, 64'd0);
    @(negedge clk);
    chk("rdy_pulse", {63'd0, lb_rd_rdy}, 64'd0);
    chk("rd_d_idle", {32'd0, lb_rd_d}, 64'd0);

    // 2. config and ctrl
    wr(8'h02, 32'h0000_0021);
    chk("cfg_pin0", {60'd0, pin_cfg[3:0]}, {60'd0, CFG_TOTEM});
    chk("cfg_pin1", {60'd0, pin_cfg[7:4]}, {60'd0, CFG_OPEN_DRAIN});
    rd(8'h02, d);
    chk("cfg0_rd", {32'd0, d}, 64'h21);
    wr(8'h00, 32'h3);
    chk("ctrl_w", {48'd0, pin_ctrl}, 64'h3);
    wr(8'h03, 32'hFFFF_FFFF);
    chk("cfg1_w", {32'd0, pin_cfg[63:32]}, 64'hFFFF_FFFF);
    wr(8'h04, 32'hFFFF_FFFF);
    rd(8'h04, d);
    chk("cfg2_unmapped", {32'd0, d}, 64'd0);
    chk("cfg_untouched", pin_cfg, 64'hFFFF_FFFF_0000_0021);
    rd(8'h20, d);
    chk("unmapped_rd", {32'd0, d}, 64'd0);
    wr(8'h17, 32'h7FFF_FFFF);
    rd(8'h17, d);
    chk("pwm7_reserved", {32'd0, d}, 64'h00FF_00FF);

    // 3. PWM waveform, P=0, N=9
    wr(8'h08, 32'h0);
    wr(8'h10, pwm(1, 9, 3));
    sample(20, 0, v);
    e = '0;
    for (int i = 0; i < 20; i++) e[i] = (i % 10) < 3;
    chk("pwm_d3", v, e);
    wr(8'h10, pwm(0, 9, 0));
    chk("pwm_dis", {63'd0, pwm_pin[0]}, 64'd0);
    wr(8'h10, pwm(1, 9, 0));
    sample(20, 0, v);
    chk("pwm_d0", v, 64'd0);
    wr(8'h10, pwm(0, 9, 0));
    wr(8'h10, pwm(1, 9, 10));
    sample(20, 0, v);
    chk("pwm_d10", v, 64'h000F_FFFF);

    // 4. shadow update mid-period
    wr(8'h10, pwm(0, 9, 3));
    wr(8'h10, pwm(1, 9, 3));
    repeat (4) @(negedge clk);
    wr(8'h10, pwm(1, 4, 2));
    sample(15, 0, v);
    e = '0;
    for (int i = 5; i < 15; i++) e[i] = ((i - 5) % 5) < 2;
    chk("pwm_shadow", v, e);

    // 5. status sync and wr+rd collision
    pin_status = 16'h0010;
    rd(8'h01, d);
    chk("sts_1clk", {32'd0, d}, 64'd0);
    rd(8'h01, d);
    chk("sts_2clk", {32'd0, d}, 64'd0);
    rd(8'h01, d);
    chk("sts_3clk", {32'd0, d}, 64'h10);
    lb_wr = 1'b1; lb_rd = 1'b1;
    lb_addr = 8'h00; lb_wr_d = 32'h0000_00A5;
    @(negedge clk);
    lb_wr = 1'b0; lb_rd = 1'b0;
    chk("wrrd_old", {32'd0, lb_rd_d}, 64'h3);
    chk("wrrd_ctrl", {48'd0, pin_ctrl}, 64'hA5);
    rd(8'h00, d);
    chk("wrrd_new", {32'd0, d}, 64'hA5);

    // 6. prescaled PWM, then reset mid-period
    wr(8'h08, 32'h3);
    rd(8'h08, d);
    chk("pre_rd", {32'd0, d}, 64'h3);
    wr(8'h10, pwm(0, 9, 3));
    wr(8'h10, pwm(1, 9, 3));
    wr(8'h11, pwm(1, 0, 1));
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      hi += int'(pwm_pin[0]);
      @(negedge clk);
    end
    chk("pre3_highs", 64'(hi), 64'd12);
    chk("n0_const", {63'd0, pwm_pin[1]}, 64'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_pwm", {56'd0, pwm_pin}, 64'd0);
    chk("mid_rst_ctrl", {48'd0, pin_ctrl}, 64'd0);
    rd(8'h10, d);
    chk("mid_rst_pwm0", {32'd0, d}, 64'd0);
    rd(8'h11, d);
    chk("mid_rst_pwm1", {32'd0, d}, 64'd0);
    rd(8'h08, d);
    chk("mid_rst_pre", {32'd0, d}, 64'd0);
    wr(8'h10, pwm(1, 1, 1));
    sample(4, 0, v);
    chk("post_rst_pwm", v, 64'h5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
